main_control_unit: RTL and testbench
====================================

// Module: main_control_unit
// PURPOSE
//   Main control decoder for the single-cycle RV32I core.
//   Decodes the 7-bit instruction opcode into datapath control strobes: branch, memory, ALU source, writeback, ALU op class.
//   Outputs are registered, and an opcode-illegal flag is provided.
//   Sits between instruction fetch/decode and the datapath muxes, ALU control, data memory and register file.
// PARAMETERS
//   none (all encodings are fixed constants in main_control_pkg)
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous, active-low reset
//   en         in   1  decode enable; 0 = hold all outputs
//   opcode     in   7  instruction[6:0]
//   branch     out  1  PC-redirect candidate (conditional branch or jump)
//   memread    out  1  data-memory read
//   memtoreg   out  2  writeback select: 00=ALU, 01=memory, 10=PC+4
//   memwrite   out  1  data-memory write
//   alusrc     out  1  ALU operand B: 0=rs2, 1=immediate
//   reg_write  out  1  register-file write enable
//   aluop      out  3  ALU op class to ALU control
//   illegal    out  1  opcode not recognised
// BEHAVIOUR
//   One clock; reset is asynchronous and active-low.
//   While rst_n=0, all outputs are 0 immediately, independent of clk.
//   Reset release takes effect at the next rising edge.
//   On each rising edge with en=1: outputs <= decode(opcode), so latency is 1 cycle.
//   On each rising edge with en=0: all outputs hold their previous value.
//   Decode table, listed as br mr m2r mw src rw aluop ill:
//     0110011 R-type  : 0 0 00 0 0 1 010 0
//     0010011 I-ALU   : 0 0 00 0 1 1 011 0
//     0000011 LOAD    : 0 1 01 0 1 1 000 0
//     0100011 STORE   : 0 0 00 1 1 0 000 0
//     1100011 BRANCH  : 1 0 00 0 0 0 001 0
//     1101111 JAL     : 1 0 10 0 0 1 100 0
//     0110111 LUI     : 0 0 00 0 1 1 101 0
//     other (incl. 0000000, 1111111): all strobes 0, aluop=000, illegal=1
//   Safety invariants, all cycles:
//     memread and memwrite are never both 1.
//     Illegal opcodes never assert reg_write, memwrite or branch.
//   Opcode X/Z is decoded as illegal (default arm) and must not propagate X.
//   Decode is a pure function of opcode; funct3/funct7 are handled by ALU control.
// CONFIGURATION
//   MAIN_CTRL_EXT_OPS_EN defined: two additional opcodes decode as follows.
//     1100111 JALR  : 1 0 10 0 1 1 100 0
//     0010111 AUIPC : 0 0 00 0 1 1 110 0
//   MAIN_CTRL_EXT_OPS_EN undefined: both opcodes fall to the default arm (illegal=1, strobes 0).
// STRUCTURE
//   main_control_pkg holds:
//     opcode localparams (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_JALR, OP_AUIPC)
//     aluop codes (ALUOP_ADD=000, BR=001, R=010, I=011, JUMP=100, LUI=101, AUIPC=110)
//     memtoreg codes (WB_ALU, WB_MEM, WB_PC4)
//     a packed ctrl_t struct for the control bundle
//   Sub-module main_control_dec: purely combinational opcode -> ctrl_t case decoder.
//   Top level: main_control_dec plus one async-reset, enable-gated output register.
// TESTING
//   1. rst_n=0 with opcode=0110011, clk running -> all outputs 0.
//      Deassert rst_n, edge -> reg_write=1, aluop=010.
//   2. en=1; apply each opcode, one per cycle -> outputs match the table one edge later:
//        0000011 -> memread=1, memtoreg=01, alusrc=1, reg_write=1
//        0100011 -> memwrite=1, reg_write=0
//        1100011 -> branch=1, aluop=001
//        1101111 -> branch=1, memtoreg=10, aluop=100
//        0110111 -> alusrc=1, aluop=101
//   3. opcode=1111111 then 0000000 -> illegal=1, all strobes 0, aluop=000.
//   4. Load decoded, then en=0 with opcode=0100011 for 3 edges -> memread stays 1, memwrite stays 0.
//      en=1 -> store values on the next edge.
//   5. Assert rst_n=0 mid-cycle between edges while outputs show JAL -> outputs go 0 without a clock edge.
//   6. opcode=1100111: with MAIN_CTRL_EXT_OPS_EN -> branch=1, alusrc=1, memtoreg=10, illegal=0;
//      without the macro -> illegal=1.

Source files
------------

// File: rtl/main_control_pkg.sv
// Shared encodings for the RV32I main control decoder: opcodes, ALU op
// classes, writeback selects and the packed control bundle.
// The JALR/AUIPC opcodes below are only decoded when MAIN_CTRL_EXT_OPS_EN is defined.
package main_control_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_BR    = 3'b001;
    localparam logic [2:0] ALUOP_R     = 3'b010;
    localparam logic [2:0] ALUOP_I     = 3'b011;
    localparam logic [2:0] ALUOP_JUMP  = 3'b100;
    localparam logic [2:0] ALUOP_LUI   = 3'b101;
    localparam logic [2:0] ALUOP_AUIPC = 3'b110;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Field order matches the decode table: br mr m2r mw src rw aluop ill
    typedef struct packed {
        logic       branch;
        logic       memread;
        logic [1:0] memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       reg_write;
        logic [2:0] aluop;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_ILLEGAL = '{branch: 1'b0, memread: 1'b0, memtoreg: WB_ALU,
                                       memwrite: 1'b0, alusrc: 1'b0, reg_write: 1'b0,
                                       aluop: ALUOP_ADD, illegal: 1'b1};

endpackage

// File: rtl/main_control_if.sv
// Decode request (en/opcode) and registered control strobes between the
// fetch/decode stage (master) and the main control unit (slave).
interface main_control_if;
    import main_control_pkg::*;

    logic       en;
    logic [6:0] opcode;
    logic       branch;
    logic       memread;
    logic [1:0] memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       reg_write;
    logic [2:0] aluop;
    logic       illegal;

    modport master (
        output en, opcode,
        input  branch, memread, memtoreg, memwrite, alusrc, reg_write, aluop, illegal
    );

    modport slave (
        input  en, opcode,
        output branch, memread, memtoreg, memwrite, alusrc, reg_write, aluop, illegal
    );
endinterface

// File: rtl/main_control_dec.sv
// Purely combinational opcode -> control bundle decoder.
// MAIN_CTRL_EXT_OPS_EN adds JALR and AUIPC; otherwise they decode as illegal.
module main_control_dec
    import main_control_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    // Start from the illegal bundle so unknown or X/Z opcodes leave every strobe low
    always_comb begin
        ctrl = CTRL_ILLEGAL;
        case (opcode)
            OP_RTYPE:  ctrl = '{1'b0, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b1, ALUOP_R,    1'b0};
            OP_ITYPE:  ctrl = '{1'b0, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b1, ALUOP_I,    1'b0};
            OP_LOAD:   ctrl = '{1'b0, 1'b1, WB_MEM, 1'b0, 1'b1, 1'b1, ALUOP_ADD,  1'b0};
            OP_STORE:  ctrl = '{1'b0, 1'b0, WB_ALU, 1'b1, 1'b1, 1'b0, ALUOP_ADD,  1'b0};
            OP_BRANCH: ctrl = '{1'b1, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b0, ALUOP_BR,   1'b0};
            OP_JAL:    ctrl = '{1'b1, 1'b0, WB_PC4, 1'b0, 1'b0, 1'b1, ALUOP_JUMP, 1'b0};
            OP_LUI:    ctrl = '{1'b0, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b1, ALUOP_LUI,  1'b0};
`ifdef MAIN_CTRL_EXT_OPS_EN
            OP_JALR:   ctrl = '{1'b1, 1'b0, WB_PC4, 1'b0, 1'b1, 1'b1, ALUOP_JUMP,  1'b0};
            OP_AUIPC:  ctrl = '{1'b0, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b1, ALUOP_AUIPC, 1'b0};
`endif
            default:   ctrl = CTRL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/main_control_unit.sv
// Main control unit for the single-cycle RV32I core: opcode decoder followed
// by one enable-gated, asynchronously reset output register (1-cycle latency).
// Optional JALR/AUIPC decode is enabled by defining MAIN_CTRL_EXT_OPS_EN.
module main_control_unit
    import main_control_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    main_control_if.slave bus
);

    ctrl_t ctrl_next;
    ctrl_t ctrl_reg;

    main_control_dec u_dec (
        .opcode (bus.opcode),
        .ctrl   (ctrl_next)
    );

    // Output register: cleared at once by reset, loads the decode only when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg <= '0;
        end else if (bus.en) begin
            ctrl_reg <= ctrl_next;
        end
    end

    assign bus.branch    = ctrl_reg.branch;
    assign bus.memread   = ctrl_reg.memread;
    assign bus.memtoreg  = ctrl_reg.memtoreg;
    assign bus.memwrite  = ctrl_reg.memwrite;
    assign bus.alusrc    = ctrl_reg.alusrc;
    assign bus.reg_write = ctrl_reg.reg_write;
    assign bus.aluop     = ctrl_reg.aluop;
    assign bus.illegal   = ctrl_reg.illegal;

endmodule

// File: tb/tb_main_control_unit.sv
// Directed bench for main_control_unit. Observed bundle order:
// br mr m2r(2) mw src rw aluop(3) ill.
module tb_main_control_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    main_control_if bus ();

    main_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [10:0] obs;
    assign obs = {bus.branch, bus.memread, bus.memtoreg, bus.memwrite, bus.alusrc,
                  bus.reg_write, bus.aluop, bus.illegal};

    localparam logic [10:0] E_ZERO  = 11'b0_0_00_0_0_0_000_0;
    localparam logic [10:0] E_R     = 11'b0_0_00_0_0_1_010_0;
    localparam logic [10:0] E_I     = 11'b0_0_00_0_1_1_011_0;
    localparam logic [10:0] E_LOAD  = 11'b0_1_01_0_1_1_000_0;
    localparam logic [10:0] E_STORE = 11'b0_0_00_1_1_0_000_0;
    localparam logic [10:0] E_BR    = 11'b1_0_00_0_0_0_001_0;
    localparam logic [10:0] E_JAL   = 11'b1_0_10_0_0_1_100_0;
    localparam logic [10:0] E_LUI   = 11'b0_0_00_0_1_1_101_0;
    localparam logic [10:0] E_ILL   = 11'b0_0_00_0_0_0_000_1;
    localparam logic [10:0] E_JALR  = 11'b1_0_10_0_1_1_100_0;
    localparam logic [10:0] E_AUIPC = 11'b0_0_00_0_1_1_110_0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.opcode = 7'b0110011;
        #2;
        total++;
        if (obs !== E_ZERO) begin
            bad++;
            $display("FAIL reset_async: got %b want %b", obs, E_ZERO);
        end
        tick();
        tick();
        total++;
        if (obs !== E_ZERO) begin
            bad++;
            $display("FAIL reset_clocked: got %b want %b", obs, E_ZERO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (obs !== E_R) begin
            bad++;
            $display("FAIL reset_release_rtype: got %b want %b", obs, E_R);
        end
        $display("test_reset: opcode=0110011 out=%b", obs);
    endtask

    task automatic test_decode();
        logic [6:0]  ops [7];
        logic [10:0] exps [7];
        ops[0] = 7'b0000011; exps[0] = E_LOAD;
        ops[1] = 7'b0100011; exps[1] = E_STORE;
        ops[2] = 7'b1100011; exps[2] = E_BR;
        ops[3] = 7'b1101111; exps[3] = E_JAL;
        ops[4] = 7'b0110111; exps[4] = E_LUI;
        ops[5] = 7'b0010011; exps[5] = E_I;
        ops[6] = 7'b0110011; exps[6] = E_R;
        bus.en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.opcode = ops[i];
            tick();
            total++;
            if (obs !== exps[i]) begin
                bad++;
                $display("FAIL decode_%b: got %b want %b", ops[i], obs, exps[i]);
            end
            total++;
            if ((bus.memread & bus.memwrite) !== 1'b0) begin
                bad++;
                $display("FAIL mem_exclusive_%b: memread=%b memwrite=%b want not both 1",
                         ops[i], bus.memread, bus.memwrite);
            end
            $display("test_decode: opcode=%b out=%b", ops[i], obs);
        end
    endtask

    task automatic test_illegal();
        logic [6:0] ops [3];
        ops[0] = 7'b1111111;
        ops[1] = 7'b0000000;
        ops[2] = 7'bxxxxxxx;
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.opcode = ops[i];
            tick();
            total++;
            if (obs !== E_ILL) begin
                bad++;
                $display("FAIL illegal_%b: got %b want %b", ops[i], obs, E_ILL);
            end
            $display("test_illegal: opcode=%b out=%b", ops[i], obs);
        end
    endtask

    task automatic test_back_to_back();
        bus.en = 1'b1;
        bus.opcode = 7'b0000011;
        tick();
        total++;
        if (obs !== E_LOAD) begin
            bad++;
            $display("FAIL hold_load_setup: got %b want %b", obs, E_LOAD);
        end
        bus.en = 1'b0;
        bus.opcode = 7'b0100011;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== E_LOAD) begin
                bad++;
                $display("FAIL hold_edge%0d: got %b want %b", i, obs, E_LOAD);
            end
            $display("test_back_to_back: en=0 edge=%0d out=%b", i, obs);
        end
        bus.en = 1'b1;
        tick();
        total++;
        if (obs !== E_STORE) begin
            bad++;
            $display("FAIL hold_release_store: got %b want %b", obs, E_STORE);
        end
        $display("test_back_to_back: en=1 out=%b", obs);
    endtask

    task automatic test_async_reset();
        bus.en = 1'b1;
        bus.opcode = 7'b1101111;
        tick();
        total++;
        if (obs !== E_JAL) begin
            bad++;
            $display("FAIL areset_jal_setup: got %b want %b", obs, E_JAL);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== E_ZERO) begin
            bad++;
            $display("FAIL areset_midcycle: got %b want %b", obs, E_ZERO);
        end
        $display("test_async_reset: mid-cycle reset out=%b", obs);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (obs !== E_JAL) begin
            bad++;
            $display("FAIL areset_release_jal: got %b want %b", obs, E_JAL);
        end
        $display("test_async_reset: released out=%b", obs);
    endtask

    task automatic test_ext_ops();
        logic [10:0] exp_jalr;
        logic [10:0] exp_auipc;
`ifdef MAIN_CTRL_EXT_OPS_EN
        exp_jalr  = E_JALR;
        exp_auipc = E_AUIPC;
`else
        exp_jalr  = E_ILL;
        exp_auipc = E_ILL;
`endif
        bus.en = 1'b1;
        bus.opcode = 7'b1100111;
        tick();
        total++;
        if (obs !== exp_jalr) begin
            bad++;
            $display("FAIL ext_jalr: got %b want %b", obs, exp_jalr);
        end
        $display("test_ext_ops: opcode=1100111 out=%b", obs);
        bus.opcode = 7'b0010111;
        tick();
        total++;
        if (obs !== exp_auipc) begin
            bad++;
            $display("FAIL ext_auipc: got %b want %b", obs, exp_auipc);
        end
        $display("test_ext_ops: opcode=0010111 out=%b", obs);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_decode();
        test_illegal();
        test_back_to_back();
        test_async_reset();
        test_ext_ops();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
